// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: opcode classes, branch FSM states, scoreboard slot layout.
package pipeline_pkg;

  localparam int unsigned CNT_W   = 4;  // load countdown, holds LOAD_LAT up to 15
  localparam int unsigned FCNT_W  = 3;  // flush countdown, holds BR_PENALTY up to 7
  localparam int unsigned SB_RD_W = 8;  // widest register address a slot can hold

  localparam logic [2:0] OP_LOAD_SUFFIX = 3'b100;
  localparam logic [5:0] OP_BR_LO       = 6'h04;
  localparam logic [5:0] OP_BR_HI       = 6'h07;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_BR = 2'd1,
    FLUSH   = 2'd2
  } br_state_e;

  typedef struct packed {
    logic                 valid;
    logic [0:SB_RD_W-1]   rd;
    logic [0:CNT_W-1]     cnt;
  } sb_entry_t;

endpackage

// File: rtl/sb_entry.sv
// One scoreboard slot: tracks an in-flight load destination and counts down to forwardability.
module sb_entry
  import pipeline_pkg::*;
#(
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alloc,
  input  logic [0:REG_AW-1] alloc_rd,
  input  logic [0:CNT_W-1]  alloc_cnt,
  input  logic [0:REG_AW-1] cmp_rs1,
  input  logic [0:REG_AW-1] cmp_rs2,
  input  logic              cmp_rs2_en,
  output logic              valid,
  output logic              retire_c,
  output logic              hit_c
);

  sb_entry_t          entry_q, entry_d;
  logic [0:SB_RD_W-1] rs1_ext, rs2_ext;

  // Next slot contents: allocation wins over retirement so a freed slot is reusable at once
  always_comb begin
    entry_d = entry_q;
    if (alloc) begin
      entry_d.valid = 1'b1;
      entry_d.rd    = SB_RD_W'(alloc_rd);
      entry_d.cnt   = alloc_cnt;
    end else if (entry_q.valid) begin
      if (entry_q.cnt == CNT_W'(1)) begin
        entry_d = '0;
      end else begin
        entry_d.cnt = entry_q.cnt - CNT_W'(1);
      end
    end
  end

  // Slot register
  always_ff @(posedge clk) begin
    if (reset) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

  // Source compare; r0 never matches
  always_comb begin
    rs1_ext  = SB_RD_W'(cmp_rs1);
    rs2_ext  = SB_RD_W'(cmp_rs2);
    valid    = entry_q.valid;
    retire_c = entry_q.valid & (entry_q.cnt == CNT_W'(1));
    hit_c    = entry_q.valid & (|entry_q.rd) &
               ((entry_q.rd == rs1_ext) | (cmp_rs2_en & (entry_q.rd == rs2_ext)));
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Load-use scoreboard plus branch hold/flush sequencer for the decode stage.
// Optional: define HAZARD_PERF_EN to add saturating stall/flush performance counters.
module hazard_scoreboard
  import pipeline_pkg::*;
#(
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned OP_W       = 6,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned LOAD_LAT   = 2,
  parameter int unsigned BR_PENALTY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [0:OP_W-1]   id_op,
  input  logic [0:REG_AW-1] id_rd,
  input  logic [0:REG_AW-1] id_rs1,
  input  logic [0:REG_AW-1] id_rs2,
  input  logic              id_uses_rs2,
  input  logic              br_resolve,
  input  logic              br_taken,
  output logic              stall,
  output logic              flush,
  output logic              issue,
  output logic              sb_full
`ifdef HAZARD_PERF_EN
  ,
  output logic [0:31]       perf_raw_stalls,
  output logic [0:31]       perf_br_stalls,
  output logic [0:31]       perf_flushes
`endif
);

  // Parameter range guards
  if (LOAD_LAT < 1 || LOAD_LAT > 15) begin : g_bad_load_lat
    $error("hazard_scoreboard: LOAD_LAT must be 1..15");
  end
  if (BR_PENALTY < 1 || BR_PENALTY > 7) begin : g_bad_br_penalty
    $error("hazard_scoreboard: BR_PENALTY must be 1..7");
  end
  if (DEPTH < 1) begin : g_bad_depth
    $error("hazard_scoreboard: DEPTH must be >= 1");
  end
  if (REG_AW < 1 || REG_AW > SB_RD_W || OP_W < 6) begin : g_bad_widths
    $error("hazard_scoreboard: REG_AW must be 1..8 and OP_W >= 6");
  end

  logic             is_load, is_branch, raw_hit, any_retire;
  logic             raw_full_stall, br_wait_stall, alloc_req, found;
  logic [DEPTH-1:0] ent_valid, ent_retire, ent_hit, ent_alloc, valid_nxt;

  br_state_e          state_q, state_d;
  logic [0:FCNT_W-1]  fcnt_q, fcnt_d;
  logic               sb_full_q, sb_full_d;

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    sb_entry #(.REG_AW(REG_AW)) u_ent (
      .clk        (clk),
      .reset      (reset),
      .alloc      (ent_alloc[i]),
      .alloc_rd   (id_rd),
      .alloc_cnt  (CNT_W'(LOAD_LAT)),
      .cmp_rs1    (id_rs1),
      .cmp_rs2    (id_rs2),
      .cmp_rs2_en (id_uses_rs2),
      .valid      (ent_valid[i]),
      .retire_c   (ent_retire[i]),
      .hit_c      (ent_hit[i])
    );
  end

  // Decode classification and hazard outputs from current state
  always_comb begin
    is_load        = (id_op[OP_W-3:OP_W-1] == OP_LOAD_SUFFIX);
    is_branch      = (id_op >= OP_W'(OP_BR_LO)) && (id_op <= OP_W'(OP_BR_HI));
    any_retire     = |ent_retire;
    raw_hit        = id_valid & (|ent_hit);
    raw_full_stall = id_valid & (raw_hit | (is_load & sb_full_q & ~any_retire));
    br_wait_stall  = id_valid & (state_q == WAIT_BR);
    stall          = raw_full_stall | br_wait_stall;
    flush          = (state_q == FLUSH);
    issue          = id_valid & ~stall & ~flush;
    sb_full        = sb_full_q;
  end

  // Lowest-index free (or retiring) slot takes an issuing load
  always_comb begin
    ent_alloc = '0;
    found     = 1'b0;
    alloc_req = issue & is_load & (|id_rd);
    for (int i = 0; i < DEPTH; i++) begin
      if (!found && (!ent_valid[i] || ent_retire[i])) begin
        ent_alloc[i] = alloc_req;
        found        = 1'b1;
      end
    end
    valid_nxt = ent_alloc | (ent_valid & ~ent_retire);
    sb_full_d = &valid_nxt;
  end

  // Branch sequencer next state
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      IDLE: begin
        if (issue && is_branch) state_d = WAIT_BR;
      end
      WAIT_BR: begin
        if (br_resolve) begin
          if (br_taken) begin
            state_d = FLUSH;
            fcnt_d  = FCNT_W'(BR_PENALTY);
          end else begin
            state_d = IDLE;
          end
        end
      end
      FLUSH: begin
        if (fcnt_q == FCNT_W'(1)) begin
          state_d = IDLE;
          fcnt_d  = '0;
        end else begin
          fcnt_d = fcnt_q - FCNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        fcnt_d  = '0;
      end
    endcase
  end

  // Sequencer and full-flag registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      fcnt_q    <= '0;
      sb_full_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      fcnt_q    <= fcnt_d;
      sb_full_q <= sb_full_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [0:31] perf_raw_q, perf_raw_d;
  logic [0:31] perf_br_q, perf_br_d;
  logic [0:31] perf_fl_q, perf_fl_d;

  // Saturating event counters
  always_comb begin
    perf_raw_d = perf_raw_q;
    perf_br_d  = perf_br_q;
    perf_fl_d  = perf_fl_q;
    if (raw_full_stall && !(&perf_raw_q)) perf_raw_d = perf_raw_q + 32'd1;
    if (br_wait_stall && !(&perf_br_q))   perf_br_d  = perf_br_q + 32'd1;
    if (flush && !(&perf_fl_q))           perf_fl_d  = perf_fl_q + 32'd1;
    perf_raw_stalls = perf_raw_q;
    perf_br_stalls  = perf_br_q;
    perf_flushes    = perf_fl_q;
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_raw_q <= '0;
      perf_br_q  <= '0;
      perf_fl_q  <= '0;
    end else begin
      perf_raw_q <= perf_raw_d;
      perf_br_q  <= perf_br_d;
      perf_fl_q  <= perf_fl_d;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: two instances (LOAD_LAT 2 and 8) share stimulus and are
// compared every cycle against a cycle-numbered reference model.
module tb_hazard_scoreboard;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned OP_W   = 6;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned BRP    = 2;
  localparam int          LAT_A  = 2;
  localparam int          LAT_B  = 8;
  localparam int          LD     = 'h0C;
  localparam int          ALU    = 'h00;

  logic clk = 1'b0;
  logic reset, id_valid, id_uses_rs2, br_resolve, br_taken;
  logic [0:OP_W-1]   id_op;
  logic [0:REG_AW-1] id_rd, id_rs1, id_rs2;
  logic stall_a, flush_a, issue_a, full_a;
  logic stall_b, flush_b, issue_b, full_b;
`ifdef HAZARD_PERF_EN
  logic [0:31] pr_a, pb_a, pf_a, pr_b, pb_b, pf_b;
`endif

  always #5 clk = ~clk;

  hazard_scoreboard #(.REG_AW(REG_AW), .OP_W(OP_W), .DEPTH(DEPTH),
                      .LOAD_LAT(LAT_A), .BR_PENALTY(BRP)) dut_a (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_op(id_op), .id_rd(id_rd),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
    .br_resolve(br_resolve), .br_taken(br_taken),
    .stall(stall_a), .flush(flush_a), .issue(issue_a), .sb_full(full_a)
`ifdef HAZARD_PERF_EN
    , .perf_raw_stalls(pr_a), .perf_br_stalls(pb_a), .perf_flushes(pf_a)
`endif
  );

  hazard_scoreboard #(.REG_AW(REG_AW), .OP_W(OP_W), .DEPTH(DEPTH),
                      .LOAD_LAT(LAT_B), .BR_PENALTY(BRP)) dut_b (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_op(id_op), .id_rd(id_rd),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
    .br_resolve(br_resolve), .br_taken(br_taken),
    .stall(stall_b), .flush(flush_b), .issue(issue_b), .sb_full(full_b)
`ifdef HAZARD_PERF_EN
    , .perf_raw_stalls(pr_b), .perf_br_stalls(pb_b), .perf_flushes(pf_b)
`endif
  );

  // Reference model: pending loads as (rd, last-busy cycle); branch as wait flag + flush end cycle
  bit pv   [2][16];
  int prd  [2][16];
  int pexp [2][16];
  bit bwait [2];
  int funtil [2];
  bit exp_st [2];
  bit exp_fl [2];
  bit exp_is [2];
  bit exp_fu [2];
  int cyc;
  int total;
  int bad;

  function automatic int lat_of(input int k);
    return (k == 0) ? LAT_A : LAT_B;
  endfunction

  task automatic chk(input string tag, input int k, input logic obs, input logic expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s dut%0d cyc=%0d observed=%0b expected=%0b", tag, k, cyc, obs, expv);
    end
  endtask

  task automatic model_out(input int k);
    int cnt;
    bit raw, ret, ld;
    cnt = 0; raw = 0; ret = 0;
    ld  = (int'(id_op) % 8) == 4;
    for (int i = 0; i < 16; i++) begin
      if (pv[k][i] && pexp[k][i] >= cyc) begin
        cnt++;
        if (prd[k][i] != 0 && (prd[k][i] == int'(id_rs1) ||
            (id_uses_rs2 && prd[k][i] == int'(id_rs2)))) raw = 1;
        if (pexp[k][i] == cyc) ret = 1;
      end
    end
    exp_fl[k] = (cyc <= funtil[k]);
    exp_st[k] = id_valid && (raw || (ld && cnt == int'(DEPTH) && !ret) || bwait[k]);
    exp_is[k] = id_valid && !exp_st[k] && !exp_fl[k];
    exp_fu[k] = (cnt == int'(DEPTH));
  endtask

  task automatic model_edge(input int k);
    bit ld, br, done;
    ld = (int'(id_op) % 8) == 4;
    br = (int'(id_op) >= 4) && (int'(id_op) <= 7);
    if (reset) begin
      for (int i = 0; i < 16; i++) pv[k][i] = 0;
      bwait[k]  = 0;
      funtil[k] = -1;
    end else begin
      if (exp_is[k] && ld && int'(id_rd) != 0) begin
        done = 0;
        for (int i = 0; i < 16; i++) begin
          if (!done && (!pv[k][i] || pexp[k][i] <= cyc)) begin
            pv[k][i]   = 1;
            prd[k][i]  = int'(id_rd);
            pexp[k][i] = cyc + lat_of(k);
            done       = 1;
          end
        end
      end
      if (bwait[k]) begin
        if (br_resolve) begin
          bwait[k] = 0;
          if (br_taken) funtil[k] = cyc + int'(BRP);
        end
      end else if (exp_is[k] && br) begin
        bwait[k] = 1;
      end
    end
  endtask

  // Called at posedge+1: settle, compare both instances, advance model across the edge
  task automatic step();
    #3;
    for (int k = 0; k < 2; k++) model_out(k);
    if (!reset) begin
      chk("stall",   0, stall_a, exp_st[0]);
      chk("flush",   0, flush_a, exp_fl[0]);
      chk("issue",   0, issue_a, exp_is[0]);
      chk("sb_full", 0, full_a,  exp_fu[0]);
      chk("stall",   1, stall_b, exp_st[1]);
      chk("flush",   1, flush_b, exp_fl[1]);
      chk("issue",   1, issue_b, exp_is[1]);
      chk("sb_full", 1, full_b,  exp_fu[1]);
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_edge(k);
    cyc++;
    #1;
  endtask

  task automatic drive(input bit v, input int op, input int rd, input int rs1, input int rs2,
                       input bit u2, input bit res, input bit tk);
    id_valid    = v;
    id_op       = OP_W'(op);
    id_rd       = REG_AW'(rd);
    id_rs1      = REG_AW'(rs1);
    id_rs2      = REG_AW'(rs2);
    id_uses_rs2 = u2;
    br_resolve  = res;
    br_taken    = tk;
    step();
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, ALU, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int sel, op;
    cyc = 0; total = 0; bad = 0;
    funtil[0] = -1; funtil[1] = -1;
    reset = 1'b1;
    id_valid = 0; id_op = '0; id_rd = '0; id_rs1 = '0; id_rs2 = '0;
    id_uses_rs2 = 0; br_resolve = 0; br_taken = 0;
    @(posedge clk); #1;
    idle(2);
    reset = 1'b0;
    idle(1);

    // Load-use on rs1, then an unrelated source
    drive(1, LD, 3, 0, 0, 0, 0, 0);
    repeat (4) drive(1, ALU, 8, 3, 0, 0, 0, 0);
    idle(10);
    drive(1, LD, 3, 0, 0, 0, 0, 0);
    drive(1, ALU, 8, 4, 0, 0, 0, 0);
    idle(10);

    // r0 load never tracked; rs2 only compared when used
    drive(1, LD, 0, 0, 0, 0, 0, 0);
    drive(1, ALU, 8, 0, 0, 0, 0, 0);
    drive(1, LD, 5, 0, 0, 0, 0, 0);
    drive(1, ALU, 8, 1, 5, 0, 0, 0);
    idle(10);
    drive(1, LD, 5, 0, 0, 0, 0, 0);
    repeat (3) drive(1, ALU, 8, 1, 5, 1, 0, 0);
    idle(10);

    // Fill the scoreboard, then a fifth load waits for a retirement
    for (int r = 1; r <= 4; r++) drive(1, LD, r, 0, 0, 0, 0, 0);
    repeat (10) drive(1, LD, 6, 0, 0, 0, 0, 0);
    idle(12);

    // Taken branch: hold, resolve, flush
    drive(1, 'h05, 0, 0, 0, 0, 0, 0);
    repeat (3) drive(1, ALU, 8, 1, 2, 1, 0, 0);
    drive(1, ALU, 8, 1, 2, 1, 1, 1);
    repeat (4) drive(1, ALU, 8, 1, 2, 1, 0, 0);

    // Not-taken branch, then a non-branch opcode just above the range
    drive(1, 'h04, 0, 0, 0, 0, 0, 0);
    repeat (2) drive(1, ALU, 8, 1, 2, 0, 0, 0);
    drive(1, ALU, 8, 1, 2, 0, 1, 0);
    repeat (2) drive(1, ALU, 8, 1, 2, 0, 0, 0);
    drive(1, 'h08, 0, 0, 0, 0, 0, 0);
    repeat (2) drive(1, ALU, 8, 1, 2, 0, 0, 0);
    idle(10);

    // Reset while flushing with two loads outstanding
    drive(1, LD, 7, 0, 0, 0, 0, 0);
    drive(1, LD, 9, 0, 0, 0, 0, 0);
    drive(1, 'h06, 0, 0, 0, 0, 0, 0);
    drive(1, ALU, 8, 0, 0, 0, 1, 1);
    drive(1, ALU, 8, 0, 0, 0, 0, 0);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    idle(1);
    drive(1, ALU, 8, 7, 9, 1, 0, 0);
    idle(2);

    // Random traffic with occasional resets
    repeat (600) begin
      reset = ($urandom_range(0, 99) == 0);
      sel = int'($urandom_range(0, 5));
      case (sel)
        0: op = LD;
        1: op = 'h14;
        2: op = 4 + int'($urandom_range(0, 3));
        3: op = ALU;
        default: op = int'($urandom_range(0, 63));
      endcase
      drive($urandom_range(0, 3) != 0, op, int'($urandom_range(0, 7)),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)));
    end
    reset = 1'b0;
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
